// File: rtl/memory_map_controller.sv
// memory_map_controller: decodes core load/store requests onto N memory-mapped slave regions.
// Optional `ACK_TIMEOUT_EN: abandon an access with rsp_err after TIMEOUT cycles without an ack.
module memory_map_controller #(
  parameter int N_REGIONS = 4,
  parameter int DW        = 32,
  parameter int LAW       = 10,
  parameter logic [N_REGIONS*32-1:0] REGION_BASE  =
    {32'h1004_0000, 32'hFFFF_0000, 32'h0040_0000, 32'h1001_0000},
  parameter logic [N_REGIONS*32-1:0] REGION_WORDS =
    {32'd256, 32'd16, 32'd1024, 32'd1024},
  parameter int TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_we,
  input  logic [DW-1:0]           req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    rsp_err,
  output logic [N_REGIONS-1:0]    bus_sel,
  output logic                    bus_we,
  output logic [LAW-1:0]          bus_addr,
  output logic [DW-1:0]           bus_wdata,
  input  logic [N_REGIONS*DW-1:0] bus_rdata,
  input  logic [N_REGIONS-1:0]    bus_ack,
  output logic [1:0]              state_dbg
);

  // Handshakes: a request transfers on req_valid & req_ready, a response on
  // rsp_valid & rsp_ready; the controller holds its side stable until transfer.

  localparam int          BYTES      = DW / 8;
  localparam int          OFF        = $clog2(BYTES);
  localparam int          AW         = 33 + OFF;
  localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t               state;
  logic [N_REGIONS-1:0] hit_sel;
  logic [LAW-1:0]       hit_addr;
  logic                 aligned;
  logic                 acked;
  logic [DW-1:0]        sel_rdata;

`ifdef ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`else
  localparam int unused_timeout_cfg = TIMEOUT;
`endif

  assign state_dbg = state;

  // Descending scan so the lowest matching region index is the one that sticks.
  always_comb begin
    hit_sel  = '0;
    hit_addr = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (AW'(req_addr) >= AW'(REGION_BASE[i*32 +: 32]) &&
          AW'(req_addr) <  AW'(REGION_BASE[i*32 +: 32]) + (AW'(REGION_WORDS[i*32 +: 32]) << OFF)) begin
        hit_sel  = N_REGIONS'(1) << i;
        hit_addr = LAW'((req_addr - REGION_BASE[i*32 +: 32]) >> OFF);
      end
    end
  end

  assign aligned = (req_addr & ALIGN_MASK) == 32'd0;
  assign acked   = |(bus_ack & bus_sel);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (bus_sel[i]) sel_rdata |= bus_rdata[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      bus_sel   <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef ACK_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (|hit_sel && aligned) begin
              state     <= ACCESS;
              bus_sel   <= hit_sel;
              bus_we    <= req_we;
              bus_addr  <= hit_addr;
              bus_wdata <= req_wdata;
`ifdef ACK_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end else begin
              state <= ERROR;
            end
          end
        end
        ACCESS: begin
          if (acked) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= bus_we ? '0 : sel_rdata;
            bus_sel   <= '0;
            bus_we    <= 1'b0;
          end
`ifdef ACK_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            bus_sel   <= '0;
            bus_we    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ERROR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
